// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard stalls.
// Build option: define IDEX_FORWARD_EN for EX/MEM and MEM/WB forwarding; when it is undefined, decode stalls on any pending write.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_hold_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_addr_i,
    input  logic [REG_AW-1:0] id_rt_addr_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic              id_use_imm_i,
    input  logic [1:0]        id_alu_sel_i,
    input  logic [1:0]        id_s_i,
    input  logic              id_sel_i,
    input  logic [1:0]        id_mul_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              exm_reg_write_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [DATA_W-1:0] exm_result_i,
    input  logic              mwb_reg_write_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic [DATA_W-1:0] mwb_data_i,
    output logic              id_stall_o,
    output logic              ex_valid_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [1:0]        alu_alu_sel_o,
    output logic [1:0]        alu_s_o,
    output logic              alu_sel_o,
    output logic [1:0]        alu_mul_o,
    output logic [DATA_W-1:0] ex_store_data_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic [1:0]        alu_sel;
        logic [1:0]        s;
        logic              sel;
        logic [1:0]        mul;
    } ex_t;

    ex_t  ex_q, ex_d, load_val;
    logic hazard;
    logic rt_read;

    logic [REG_AW-1:0] src_addr [2];
    logic [DATA_W-1:0] src_data [2];
    logic [DATA_W-1:0] fwd_data [2];

    // True when a writer with destination rd clobbers a register that ID actually reads.
    function automatic logic src_hit(input logic              we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              rt_used);
        return we && (rd != '0) && ((rd == rs) || (rt_used && (rd == rt)));
    endfunction

    assign rt_read = !id_use_imm_i || id_mem_write_i;

`ifdef IDEX_FORWARD_EN
    assign hazard = src_hit(ex_q.valid && ex_q.mem_read, ex_q.rd,
                            id_rs_addr_i, id_rt_addr_i, rt_read);
`else
    assign hazard = src_hit(ex_q.valid && ex_q.reg_write, ex_q.rd,
                            id_rs_addr_i, id_rt_addr_i, rt_read)
                 || src_hit(exm_reg_write_i, exm_rd_i,
                            id_rs_addr_i, id_rt_addr_i, rt_read)
                 || src_hit(mwb_reg_write_i, mwb_rd_i,
                            id_rs_addr_i, id_rt_addr_i, rt_read);
`endif

    assign id_stall_o = !flush_i && (ex_hold_i || hazard);

    always_comb begin
        load_val           = '0;
        load_val.valid     = id_valid_i;
        load_val.rs        = id_rs_addr_i;
        load_val.rt        = id_rt_addr_i;
        load_val.rd        = id_rd_addr_i;
        load_val.reg_write = id_reg_write_i && id_valid_i;
        load_val.mem_read  = id_mem_read_i && id_valid_i;
        load_val.mem_write = id_mem_write_i && id_valid_i;
        load_val.rs_data   = id_rs_data_i;
        load_val.rt_data   = id_rt_data_i;
        load_val.imm       = id_imm_i;
        load_val.use_imm   = id_use_imm_i;
        load_val.alu_sel   = id_alu_sel_i;
        load_val.s         = id_s_i;
        load_val.sel       = id_sel_i;
        load_val.mul       = id_mul_i;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (ex_hold_i) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else begin
            ex_d = load_val;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign src_addr[0] = ex_q.rs;
    assign src_addr[1] = ex_q.rt;
    assign src_data[0] = ex_q.rs_data;
    assign src_data[1] = ex_q.rt_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
`ifdef IDEX_FORWARD_EN
            // EX/MEM is the younger result, so it beats MEM/WB.
            always_comb begin
                fwd_data[gi] = src_data[gi];
                if (exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == src_addr[gi])) begin
                    fwd_data[gi] = exm_result_i;
                end else if (mwb_reg_write_i && (mwb_rd_i != '0) && (mwb_rd_i == src_addr[gi])) begin
                    fwd_data[gi] = mwb_data_i;
                end
            end
`else
            assign fwd_data[gi] = src_data[gi];
`endif
        end
    endgenerate

`ifndef IDEX_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{exm_result_i, mwb_data_i, src_addr[0], src_addr[1]};
`endif

    assign alu_a_o         = fwd_data[0];
    assign alu_b_o         = ex_q.use_imm ? ex_q.imm : fwd_data[1];
    assign ex_store_data_o = fwd_data[1];

    assign ex_valid_o     = ex_q.valid;
    assign ex_rd_o        = ex_q.rd;
    assign ex_reg_write_o = ex_q.reg_write;
    assign ex_mem_read_o  = ex_q.mem_read;
    assign ex_mem_write_o = ex_q.mem_write;
    assign alu_alu_sel_o  = ex_q.alu_sel;
    assign alu_s_o        = ex_q.s;
    assign alu_sel_o      = ex_q.sel;
    assign alu_mul_o      = ex_q.mul;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; covers the IDEX_FORWARD_EN build or the stall-only build, whichever is compiled.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        flush, ex_hold, id_valid;
    logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm;
    logic [1:0]  id_alu_sel, id_s, id_mul;
    logic        id_sel;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exm_reg_write, mwb_reg_write;
    logic [2:0]  exm_rd, mwb_rd;
    logic [15:0] exm_result, mwb_data;
    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_rd;
    logic [15:0] alu_a, alu_b, ex_store_data;
    logic [1:0]  alu_alu_sel, alu_s, alu_mul;
    logic        alu_sel;

    int n_total = 0;
    int n_pass  = 0;

    id_ex_stage #(.DATA_W(16), .REG_AW(3)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_hold_i(ex_hold),
        .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr),
        .id_rd_addr_i(id_rd_addr), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
        .id_imm_i(id_imm), .id_use_imm_i(id_use_imm), .id_alu_sel_i(id_alu_sel),
        .id_s_i(id_s), .id_sel_i(id_sel), .id_mul_i(id_mul),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write),
        .exm_reg_write_i(exm_reg_write), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
        .mwb_reg_write_i(mwb_reg_write), .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
        .id_stall_o(id_stall), .ex_valid_o(ex_valid), .ex_rd_o(ex_rd),
        .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_alu_sel_o(alu_alu_sel), .alu_s_o(alu_s),
        .alu_sel_o(alu_sel), .alu_mul_o(alu_mul), .ex_store_data_o(ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s ok   value %h", tag, got);
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                         input logic [15:0] imm, input logic ui, input logic rw,
                         input logic mr, input logic mw);
        id_valid     = v;
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        id_rd_addr   = rd;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_imm       = imm;
        id_use_imm   = ui;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
        #1;
    endtask

`ifndef IDEX_FORWARD_EN
    int  stalls;
    bit  ex_is_add, exm_is_add, mwb_is_add;
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        id_alu_sel = 2'd0; id_s = 2'd0; id_sel = 1'b0; id_mul = 2'd0;
        exm_reg_write = 1'b0; exm_rd = 3'd0; exm_result = 16'h0;
        mwb_reg_write = 1'b0; mwb_rd = 3'd0; mwb_data = 16'h0;
        instr(1, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h0042, 0, 1, 0, 0);
        repeat (2) step();
        check("rst_valid", ex_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_store", ex_store_data, 0);
        check("rst_rd", ex_rd, 0);
        check("rst_stall", id_stall, 0);

        // Plain load of an R-type with all ALU controls non-zero.
        rst = 1'b0;
        id_alu_sel = 2'd2; id_s = 2'd1; id_sel = 1'b1; id_mul = 2'd3;
        step();
        check("ld_valid", ex_valid, 1);
        check("ld_alu_a", alu_a, 16'h1111);
        check("ld_alu_b", alu_b, 16'h2222);
        check("ld_store", ex_store_data, 16'h2222);
        check("ld_rd", ex_rd, 4);
        check("ld_rw", ex_reg_write, 1);
        check("ld_alu_sel", alu_alu_sel, 2);
        check("ld_s", alu_s, 1);
        check("ld_sel", alu_sel, 1);
        check("ld_mul", alu_mul, 3);

        // Store with immediate: B takes imm, store data still carries rt.
        id_alu_sel = 2'd0; id_s = 2'd0; id_sel = 1'b0; id_mul = 2'd0;
        instr(1, 3'd5, 3'd6, 3'd7, 16'h0505, 16'h0606, 16'h00AB, 1, 0, 0, 1);
        step();
        check("imm_alu_b", alu_b, 16'h00AB);
        check("imm_store", ex_store_data, 16'h0606);
        check("imm_mw", ex_mem_write, 1);
        check("imm_rw", ex_reg_write, 0);
        check("imm_mul", alu_mul, 0);

        // Invalid slot: control bits are gated off.
        instr(0, 3'd1, 3'd2, 3'd3, 16'h0101, 16'h0202, 16'h0, 0, 1, 1, 1);
        step();
        check("inv_valid", ex_valid, 0);
        check("inv_rw", ex_reg_write, 0);
        check("inv_mr", ex_mem_read, 0);
        check("inv_mw", ex_mem_write, 0);

        // Asynchronous reset mid-run.
        instr(1, 3'd1, 3'd2, 3'd6, 16'h0C0C, 16'h0D0D, 16'h0, 0, 1, 0, 0);
        step();
        check("pre_rst_valid", ex_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_rw", ex_reg_write, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        instr(1, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h0, 0, 1, 0, 0);
        check("post_rst_stall", id_stall, 0);
        check("post_rst_empty", ex_valid, 0);
        step();
        check("post_rst_valid", ex_valid, 1);
        check("post_rst_alu_a", alu_a, 16'h1111);

        // Downstream hold for two cycles.
        instr(1, 3'd5, 3'd6, 3'd7, 16'h9999, 16'h8888, 16'h0, 0, 0, 0, 0);
        ex_hold = 1'b1;
        #1;
        check("hold_stall", id_stall, 1);
        step();
        check("hold1_alu_a", alu_a, 16'h1111);
        step();
        check("hold2_alu_a", alu_a, 16'h1111);
        check("hold2_rd", ex_rd, 4);
        ex_hold = 1'b0;
        step();
        check("unhold_alu_a", alu_a, 16'h9999);

        // Load-use against hold, then against flush.
        instr(1, 3'd1, 3'd2, 3'd3, 16'h0011, 16'h0022, 16'h0004, 1, 1, 1, 0);
        step();
        instr(1, 3'd3, 3'd1, 3'd4, 16'h3333, 16'h0101, 16'h0, 0, 1, 0, 0);
        check("lu_stall", id_stall, 1);
        ex_hold = 1'b1;
        step();
        check("lu_hold_mr", ex_mem_read, 1);
        check("lu_hold_rd", ex_rd, 3);
        ex_hold = 1'b0;
        #1;
        check("lu_reeval", id_stall, 1);
        flush = 1'b1;
        #1;
        check("flush_stall", id_stall, 0);
        step();
        flush = 1'b0;
        #1;
        check("flush_valid", ex_valid, 0);
        check("flush_mr", ex_mem_read, 0);
        check("flush_rd", ex_rd, 0);
        check("flush_alu_a", alu_a, 0);

        // Register 0 is never forwarded and never a hazard source.
        instr(1, 3'd0, 3'd0, 3'd5, 16'h0000, 16'h0000, 16'h0010, 1, 1, 0, 0);
        exm_reg_write = 1'b1; exm_rd = 3'd0; exm_result = 16'hFFFF;
        #1;
        check("r0_stall", id_stall, 0);
        step();
        check("r0_alu_a", alu_a, 16'h0000);
        exm_reg_write = 1'b0; exm_result = 16'h0;

`ifdef IDEX_FORWARD_EN
        // lw r3 then add r4,r3,r1: one bubble, then add forwards from MEM/WB.
        instr(1, 3'd1, 3'd2, 3'd3, 16'h0011, 16'h0022, 16'h0004, 1, 1, 1, 0);
        step();
        instr(1, 3'd3, 3'd1, 3'd4, 16'h3333, 16'h0101, 16'h0, 0, 1, 0, 0);
        check("fw_lu_stall", id_stall, 1);
        step();
        check("fw_lu_bubble", ex_valid, 0);
        check("fw_lu_once", id_stall, 0);
        step();
        mwb_reg_write = 1'b1; mwb_rd = 3'd3; mwb_data = 16'h5A5A;
        #1;
        check("fw_lu_valid", ex_valid, 1);
        check("fw_lu_alu_a", alu_a, 16'h5A5A);
        check("fw_lu_alu_b", alu_b, 16'h0101);
        mwb_reg_write = 1'b0;

        // Forward priority on rs and rt (store data).
        instr(1, 3'd2, 3'd2, 3'd6, 16'h0002, 16'h0002, 16'h0077, 1, 1, 0, 0);
        step();
        exm_reg_write = 1'b1; exm_rd = 3'd2; exm_result = 16'h1234;
        mwb_reg_write = 1'b1; mwb_rd = 3'd2; mwb_data = 16'hBEEF;
        #1;
        check("fw_pri_alu_a", alu_a, 16'h1234);
        check("fw_pri_store", ex_store_data, 16'h1234);
        check("fw_pri_alu_b", alu_b, 16'h0077);
        exm_reg_write = 1'b0;
        #1;
        check("fw_mwb_alu_a", alu_a, 16'hBEEF);
        check("fw_mwb_store", ex_store_data, 16'hBEEF);
        mwb_reg_write = 1'b0;
        #1;
        check("fw_rf_alu_a", alu_a, 16'h0002);
`else
        // add r1 then dependent sub r5,r1,r2: three stall cycles, register-file operands.
        instr(1, 3'd2, 3'd3, 3'd1, 16'h0002, 16'h0003, 16'h0, 0, 1, 0, 0);
        step();
        instr(1, 3'd1, 3'd2, 3'd5, 16'h0777, 16'h0002, 16'h0, 0, 1, 0, 0);
        ex_is_add = 1'b1; exm_is_add = 1'b0; mwb_is_add = 1'b0;
        stalls = 0;
        for (int c = 0; c < 10; c++) begin
            if (!id_stall) break;
            stalls++;
            step();
            mwb_is_add = exm_is_add;
            exm_is_add = ex_is_add;
            ex_is_add  = 1'b0;
            exm_reg_write = exm_is_add; exm_rd = 3'd1; exm_result = 16'hAAAA;
            mwb_reg_write = mwb_is_add; mwb_rd = 3'd1; mwb_data = 16'hBBBB;
            #1;
            check($sformatf("nf_bubble%0d", c), ex_valid, 0);
        end
        check("nf_stall_cnt", stalls, 3);
        step();
        check("nf_sub_valid", ex_valid, 1);
        check("nf_sub_alu_a", alu_a, 16'h0777);
        check("nf_sub_alu_b", alu_b, 16'h0002);
        check("nf_sub_rd", ex_rd, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
